// File: rtl/mult_dot_accumulator.sv
// Dot-product accumulator fed by a sequential multiplier: captures each product on the
// rising edge of its ready flag, sums LEN products with saturation, and hands the result over by valid/ack.
module mult_dot_accumulator #(
    parameter int WIDTH     = 8,
    parameter int LEN       = 4,
    parameter int ACC_WIDTH = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2*WIDTH-1:0]   prod,
    input  logic                 prod_ready,
    input  logic                 clear,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 acc_valid,
    input  logic                 acc_ack,
    output logic                 overflow,
    output logic                 overrun,
    output logic [7:0]           count
);

    localparam int PW = 2 * WIDTH;
    localparam int SW = ACC_WIDTH + 1;

    localparam logic [0:0] S_ACCUM = 1'b0;
    localparam logic [0:0] S_HOLD  = 1'b1;

    logic [0:0]           r_state;
    logic                 r_ready_q;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_acc_out;
    logic [7:0]           r_count;
    logic                 r_sat;
    logic                 r_overflow;
    logic                 r_overrun;
    logic                 r_pend_full;
    logic [PW-1:0]        r_pend;

    logic                 w_new_prod;
    logic [SW-1:0]        w_sum_full;
    logic [ACC_WIDTH-1:0] w_sum_sat;
    logic                 w_sat_next;
    logic [7:0]           w_count_inc;
    logic                 w_done;
    logic                 w_has_term;
    logic [PW-1:0]        w_term;

    assign w_new_prod  = prod_ready & ~r_ready_q;
    // acc never exceeds its max and prod fits in ACC_WIDTH, so one extra bit holds any sum.
    assign w_sum_full  = {1'b0, r_acc} + SW'(prod);
    assign w_sum_sat   = w_sum_full[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_sum_full[ACC_WIDTH-1:0];
    assign w_sat_next  = r_sat | w_sum_full[ACC_WIDTH];
    assign w_count_inc = r_count + 8'd1;
    assign w_done      = (w_count_inc == 8'(LEN));

    // On ack the oldest available product (pending first, then a same-cycle capture) starts the next result.
    assign w_has_term  = r_pend_full | w_new_prod;
    assign w_term      = r_pend_full ? r_pend : prod;

    // NOTE: ready_q resets high so a ready already asserted out of reset is not seen as a new edge;
    // it ignores clear so a clear never fabricates an edge either.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ready_q <= 1'b1;
        else        r_ready_q <= prod_ready;
    end

    // NOTE: all state registers use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_ACCUM;
            r_acc       <= '0;
            r_acc_out   <= '0;
            r_count     <= '0;
            r_sat       <= 1'b0;
            r_overflow  <= 1'b0;
            r_overrun   <= 1'b0;
            r_pend_full <= 1'b0;
            r_pend      <= '0;
        end else if (clear) begin
            r_state     <= S_ACCUM;
            r_acc       <= '0;
            r_acc_out   <= '0;
            r_count     <= '0;
            r_sat       <= 1'b0;
            r_overflow  <= 1'b0;
            r_overrun   <= 1'b0;
            r_pend_full <= 1'b0;
            r_pend      <= '0;
        end else begin
            case (r_state)
                S_ACCUM: begin
                    if (w_new_prod) begin
                        if (w_done) begin
                            r_acc_out  <= w_sum_sat;
                            r_overflow <= w_sat_next;
                            r_state    <= S_HOLD;
                            r_acc      <= '0;
                            r_count    <= '0;
                            r_sat      <= 1'b0;
                        end else begin
                            r_acc      <= w_sum_sat;
                            r_count    <= w_count_inc;
                            r_sat      <= w_sat_next;
                        end
                    end
                end
                default: begin
                    if (acc_ack) begin
                        if (w_has_term && LEN == 1) begin
                            r_acc_out  <= ACC_WIDTH'(w_term);
                            r_overflow <= 1'b0;
                        end else if (w_has_term) begin
                            r_acc      <= ACC_WIDTH'(w_term);
                            r_count    <= 8'd1;
                            r_sat      <= 1'b0;
                            r_state    <= S_ACCUM;
                        end else begin
                            r_state    <= S_ACCUM;
                        end
                        // A pending product used as first term frees the slot for a same-cycle capture.
                        r_pend_full <= r_pend_full & w_new_prod;
                        if (r_pend_full && w_new_prod) r_pend <= prod;
                    end else if (w_new_prod) begin
                        if (!r_pend_full) begin
                            r_pend_full <= 1'b1;
                            r_pend      <= prod;
                        end else begin
                            r_overrun   <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign acc_out   = r_acc_out;
    assign acc_valid = (r_state == S_HOLD);
    assign overflow  = r_overflow;
    assign overrun   = r_overrun;
    assign count     = r_count;

endmodule

// File: tb/tb_mult_dot_accumulator.sv
// Bench for mult_dot_accumulator: three configurations share one stimulus stream and are
// compared every cycle against a behavioural model, with directed literal checks first.
module tb_mult_dot_accumulator;

    localparam int N = 3;
    localparam int LENS [N] = '{4, 4, 1};
    localparam int AWS  [N] = '{18, 17, 18};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] prod;
    logic        prod_ready;
    logic        clear;
    logic        acc_ack;

    logic [17:0] w_out0;
    logic [16:0] w_out1;
    logic [17:0] w_out2;
    logic        w_val [N];
    logic        w_ovf [N];
    logic        w_orun [N];
    logic [7:0]  w_cnt [N];
    logic [31:0] o_out [N];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mult_dot_accumulator #(.WIDTH(8), .LEN(4), .ACC_WIDTH(18)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .prod(prod), .prod_ready(prod_ready), .clear(clear),
        .acc_out(w_out0), .acc_valid(w_val[0]), .acc_ack(acc_ack), .overflow(w_ovf[0]),
        .overrun(w_orun[0]), .count(w_cnt[0]));

    mult_dot_accumulator #(.WIDTH(8), .LEN(4), .ACC_WIDTH(17)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .prod(prod), .prod_ready(prod_ready), .clear(clear),
        .acc_out(w_out1), .acc_valid(w_val[1]), .acc_ack(acc_ack), .overflow(w_ovf[1]),
        .overrun(w_orun[1]), .count(w_cnt[1]));

    mult_dot_accumulator #(.WIDTH(8), .LEN(1), .ACC_WIDTH(18)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .prod(prod), .prod_ready(prod_ready), .clear(clear),
        .acc_out(w_out2), .acc_valid(w_val[2]), .acc_ack(acc_ack), .overflow(w_ovf[2]),
        .overrun(w_orun[2]), .count(w_cnt[2]));

    assign o_out[0] = 32'(w_out0);
    assign o_out[1] = 32'(w_out1);
    assign o_out[2] = 32'(w_out2);

    // Behavioural model of one accumulator configuration.
    typedef struct {
        bit     rq;
        bit     valid;
        longint acc;
        int     cnt;
        bit     sat;
        bit     pfull;
        longint pval;
        longint out;
        bit     ovf;
        bit     orun;
    } mstate_t;

    mstate_t m [N];

    function automatic mstate_t mreset();
        mstate_t s;
        s = '{rq: 1'b1, valid: 1'b0, acc: 0, cnt: 0, sat: 1'b0, pfull: 1'b0,
              pval: 0, out: 0, ovf: 1'b0, orun: 1'b0};
        return s;
    endfunction

    function automatic mstate_t mstep(mstate_t s, int len, int aw, bit rdy, longint p,
                                      bit clr, bit ack);
        mstate_t n;
        longint  maxv;
        longint  sum;
        longint  terms [$];
        bit      edge_seen;
        maxv      = (longint'(1) << aw) - 1;
        edge_seen = rdy && !s.rq;
        n         = s;
        n.rq      = rdy;
        if (clr) begin
            n    = mreset();
            n.rq = rdy;
            return n;
        end
        if (!s.valid) begin
            if (edge_seen) begin
                sum = s.acc + p;
                if (sum > maxv) begin
                    sum   = maxv;
                    n.sat = 1'b1;
                end
                n.acc = sum;
                n.cnt = s.cnt + 1;
                if (n.cnt == len) begin
                    n.out   = sum;
                    n.ovf   = n.sat;
                    n.valid = 1'b1;
                    n.acc   = 0;
                    n.cnt   = 0;
                    n.sat   = 1'b0;
                end
            end
        end else if (ack) begin
            if (s.pfull) terms.push_back(s.pval);
            if (edge_seen) terms.push_back(p);
            n.pfull = 1'b0;
            n.valid = 1'b0;
            if (terms.size() > 0) begin
                if (len == 1) begin
                    n.out   = terms[0];
                    n.ovf   = 1'b0;
                    n.valid = 1'b1;
                end else begin
                    n.acc = terms[0];
                    n.cnt = 1;
                    n.sat = 1'b0;
                end
            end
            if (terms.size() > 1) begin
                n.pfull = 1'b1;
                n.pval  = terms[1];
            end
        end else if (edge_seen) begin
            if (!s.pfull) begin
                n.pfull = 1'b1;
                n.pval  = p;
            end else begin
                n.orun = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < N; k++) begin
            if (!rst_n) m[k] <= mreset();
            else        m[k] <= mstep(m[k], LENS[k], AWS[k], prod_ready, longint'(prod),
                                      clear, acc_ack);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all three configurations against the model.
    always @(negedge clk) begin
        #1;
        for (int k = 0; k < N; k++) begin
            check($sformatf("dut%0d acc_out", k),   o_out[k],         32'(m[k].out));
            check($sformatf("dut%0d acc_valid", k), 32'(w_val[k]),    32'(m[k].valid));
            check($sformatf("dut%0d overflow", k),  32'(w_ovf[k]),    32'(m[k].ovf));
            check($sformatf("dut%0d overrun", k),   32'(w_orun[k]),   32'(m[k].orun));
            check($sformatf("dut%0d count", k),     32'(w_cnt[k]),    32'(m[k].cnt));
        end
    end

    task automatic send(input logic [15:0] p);
        @(negedge clk);
        prod_ready = 1'b0;
        prod       = 16'($urandom);
        @(negedge clk);
        prod       = p;
        prod_ready = 1'b1;
        @(negedge clk);
        #2;
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        acc_ack = 1'b1;
        @(negedge clk);
        acc_ack = 1'b0;
        #2;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
        #2;
    endtask

    initial begin
        rst_n      = 1'b0;
        prod       = '0;
        prod_ready = 1'b0;
        clear      = 1'b0;
        acc_ack    = 1'b0;
        idle(3);
        check("reset acc_out", o_out[0], 32'd0);
        check("reset acc_valid", 32'(w_val[0]), 32'd0);
        check("reset count", 32'(w_cnt[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Four products 15,100,255,0 sum to 370; valid appears on the 4th capture edge.
        send(16'd15);
        check("t1 count1", 32'(w_cnt[0]), 32'd1);
        send(16'd100);
        check("t1 count2", 32'(w_cnt[0]), 32'd2);
        send(16'd255);
        check("t1 count3", 32'(w_cnt[0]), 32'd3);
        check("t1 not valid yet", 32'(w_val[0]), 32'd0);
        send(16'd0);
        check("t1 acc_out", o_out[0], 32'd370);
        check("t1 acc_valid", 32'(w_val[0]), 32'd1);
        check("t1 overflow", 32'(w_ovf[0]), 32'd0);
        check("t1 count after", 32'(w_cnt[0]), 32'd0);
        ack_pulse();
        check("t1 ack clears valid", 32'(w_val[0]), 32'd0);

        // Ready held high captures only once.
        send(16'd9);
        idle(20);
        check("t2 single capture", 32'(w_cnt[0]), 32'd1);
        send(16'd1); send(16'd1); send(16'd1);
        check("t2 acc_out", o_out[0], 32'd12);
        ack_pulse();

        // Ready already high across reset is not an edge.
        @(negedge clk);
        rst_n = 1'b0;
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        check("t3 no capture after reset", 32'(w_cnt[0]), 32'd0);
        send(16'd1); send(16'd1);
        check("t3 count2", 32'(w_cnt[0]), 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("t3 mid reset count", 32'(w_cnt[0]), 32'd0);
        check("t3 mid reset acc_out", o_out[0], 32'd0);
        check("t3 mid reset valid", 32'(w_val[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(16'd1); send(16'd1); send(16'd1); send(16'd1);
        check("t3 acc_out", o_out[0], 32'd4);
        ack_pulse();

        // Saturation in the 17-bit configuration only.
        send(16'd65025); send(16'd65025); send(16'd65025); send(16'd1);
        check("t4 sat acc_out", o_out[1], 32'd131071);
        check("t4 sat overflow", 32'(w_ovf[1]), 32'd1);
        check("t4 wide acc_out", o_out[0], 32'd195076);
        check("t4 wide overflow", 32'(w_ovf[0]), 32'd0);
        ack_pulse();
        send(16'd2); send(16'd2); send(16'd2); send(16'd2);
        check("t4 after acc_out", o_out[1], 32'd8);
        check("t4 after overflow", 32'(w_ovf[1]), 32'd0);
        ack_pulse();

        // Pending slot holds 6, 8 is dropped.
        send(16'd1); send(16'd1); send(16'd1); send(16'd1);
        send(16'd6);
        check("t5 overrun clear", 32'(w_orun[0]), 32'd0);
        send(16'd8);
        check("t5 overrun set", 32'(w_orun[0]), 32'd1);
        check("t5 result held", o_out[0], 32'd4);
        ack_pulse();
        check("t5 pending loaded", 32'(w_cnt[0]), 32'd1);
        send(16'd1); send(16'd1); send(16'd1);
        check("t5 acc_out", o_out[0], 32'd9);

        // Ack together with a new product of 12.
        @(negedge clk);
        prod_ready = 1'b0;
        @(negedge clk);
        prod       = 16'd12;
        prod_ready = 1'b1;
        acc_ack    = 1'b1;
        @(negedge clk);
        acc_ack    = 1'b0;
        #2;
        check("t6 valid dropped", 32'(w_val[0]), 32'd0);
        check("t6 count1", 32'(w_cnt[0]), 32'd1);
        send(16'd1); send(16'd1); send(16'd1);
        check("t6 acc_out", o_out[0], 32'd15);
        @(negedge clk);
        clear   = 1'b1;
        acc_ack = 1'b1;
        @(negedge clk);
        clear   = 1'b0;
        acc_ack = 1'b0;
        #2;
        check("t6 clear count", 32'(w_cnt[0]), 32'd0);
        check("t6 clear valid", 32'(w_val[0]), 32'd0);
        check("t6 clear overrun", 32'(w_orun[0]), 32'd0);

        // Random traffic; ack is rare in the first half to exercise pending/overrun.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 599) != 0);
            clear = ($urandom_range(0, 249) == 0);
            if (i < 2000) acc_ack = ($urandom_range(0, 11) == 0);
            else          acc_ack = ($urandom_range(0, 2) == 0);
            if (prod_ready) begin
                if ($urandom_range(0, 2) == 0) begin
                    prod_ready = 1'b0;
                    prod       = 16'($urandom);
                end
            end else if ($urandom_range(0, 1) == 0) begin
                prod_ready = 1'b1;
                if ($urandom_range(0, 1) == 0) prod = 16'd65025 - 16'($urandom_range(0, 600));
                else                           prod = 16'(8'($urandom) * 8'($urandom));
            end else begin
                prod = 16'($urandom);
            end
        end
        @(negedge clk);
        rst_n   = 1'b1;
        clear   = 1'b0;
        acc_ack = 1'b0;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
